// File: rtl/deserializador_alineado_pkg.sv
// Shared definitions for the comma-aligned deserialiser: FSM state encoding and
// the K28.5 comma symbols in both running disparities.
package deserializador_alineado_pkg;

  typedef enum logic [1:0] {
    BUSCANDO        = 2'd0,
    VERIFICANDO     = 2'd1,
    ALINEADO        = 2'd2,
    ESTADO_INVALIDO = 2'd3
  } estado_t;

  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;

endpackage

// File: rtl/detector_coma.sv
// Combinational comma detector: flags a window equal to the comma symbol in
// either running disparity (the pattern or its bitwise complement).
module detector_coma
  import deserializador_alineado_pkg::*;
#(
  parameter int               ANCHO = 10,
  parameter logic [ANCHO-1:0] COMA  = ANCHO'(K28_5_RDN)
) (
  input  logic [ANCHO-1:0] i_ventana,
  output logic             o_match
);

  localparam logic [ANCHO-1:0] COMA_INV = ~COMA;

  // Equality against both disparities of the comma
  always_comb begin
    if ((i_ventana == COMA) || (i_ventana == COMA_INV)) begin
      o_match = 1'b1;
    end else begin
      o_match = 1'b0;
    end
  end

endmodule

// File: rtl/deserializador_alineado.sv
// Serial-to-parallel converter that hunts for a comma, locks after a run of
// word-aligned commas and then emits one registered word per ANCHO enabled bits.
module deserializador_alineado
  import deserializador_alineado_pkg::*;
#(
  parameter int               ANCHO               = 10,
  parameter logic [ANCHO-1:0] COMA                = ANCHO'(K28_5_RDN),
  parameter bit               MSB_PRIMERO         = 1'b0,
  parameter int               COMAS_PARA_ALINEAR  = 3,
  parameter int               ERRORES_PARA_PERDER = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enb,
  input  logic             i_entrada,
  output logic [ANCHO-1:0] o_salidas,
  output logic             o_valido,
  output logic             o_es_coma,
  output logic             o_alineado
);

  localparam int FW = $clog2(ANCHO);
  localparam int CW = $clog2(COMAS_PARA_ALINEAR + 1);
  localparam int EW = $clog2(ERRORES_PARA_PERDER + 1);

  localparam logic [FW-1:0] FASE_MAX   = FW'(ANCHO - 1);
  localparam logic [FW-1:0] FASE_UNO   = FW'(1);
  localparam logic [CW-1:0] COMAS_OBJ  = CW'(COMAS_PARA_ALINEAR);
  localparam logic [CW-1:0] COMAS_UNO  = CW'(1);
  localparam logic [EW-1:0] ERR_OBJ    = EW'(ERRORES_PARA_PERDER);
  localparam logic [EW-1:0] ERR_UNO    = EW'(1);

  logic [ANCHO-1:0] r_shift;
  logic [FW-1:0]    r_fase;
  logic [CW-1:0]    r_cuenta_comas;
  logic [EW-1:0]    r_cuenta_errores;
  estado_t          r_estado;

  logic [ANCHO-1:0] w_ventana_sig;
  logic             w_match;
  logic             w_frontera;
  logic [FW-1:0]    w_fase_sig;
  logic [CW-1:0]    w_comas_inc;
  logic [EW-1:0]    w_errores_inc;

  // Window as it will look once the current bit has been shifted in
  always_comb begin
    if (MSB_PRIMERO) begin
      w_ventana_sig = {r_shift[ANCHO-2:0], i_entrada};
    end else begin
      w_ventana_sig = {i_entrada, r_shift[ANCHO-1:1]};
    end
  end

  detector_coma #(
    .ANCHO (ANCHO),
    .COMA  (COMA)
  ) u_detector (
    .i_ventana (w_ventana_sig),
    .o_match   (w_match)
  );

  // Bit phase within the word and its wrap-around
  always_comb begin
    w_frontera = (r_fase == FASE_MAX);
    if (w_frontera) begin
      w_fase_sig = '0;
    end else begin
      w_fase_sig = r_fase + FASE_UNO;
    end
  end

  // Saturating increments for both comma counters
  always_comb begin
    if (r_cuenta_comas == COMAS_OBJ) begin
      w_comas_inc = r_cuenta_comas;
    end else begin
      w_comas_inc = r_cuenta_comas + COMAS_UNO;
    end
    if (r_cuenta_errores == ERR_OBJ) begin
      w_errores_inc = r_cuenta_errores;
    end else begin
      w_errores_inc = r_cuenta_errores + ERR_UNO;
    end
  end

  // Shift register, phase counter, alignment FSM and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_shift          <= '0;
      r_fase           <= '0;
      r_cuenta_comas   <= '0;
      r_cuenta_errores <= '0;
      r_estado         <= BUSCANDO;
      o_salidas        <= '0;
      o_valido         <= 1'b0;
      o_es_coma        <= 1'b0;
      o_alineado       <= 1'b0;
    end else if (!i_enb) begin
      o_valido <= 1'b0;
    end else begin
      r_shift  <= w_ventana_sig;
      r_fase   <= w_fase_sig;
      o_valido <= 1'b0;
      case (r_estado)
        BUSCANDO: begin
          o_alineado <= 1'b0;
          if (w_match) begin
            // The comma just completed defines the word boundary
            r_fase         <= '0;
            r_cuenta_comas <= COMAS_UNO;
            if (COMAS_PARA_ALINEAR == 1) begin
              r_estado         <= ALINEADO;
              r_cuenta_errores <= '0;
              o_alineado       <= 1'b1;
            end else begin
              r_estado <= VERIFICANDO;
            end
          end
        end
        VERIFICANDO: begin
          if (w_frontera) begin
            if (w_match) begin
              r_cuenta_comas <= w_comas_inc;
              if (w_comas_inc == COMAS_OBJ) begin
                r_estado         <= ALINEADO;
                r_cuenta_errores <= '0;
                o_alineado       <= 1'b1;
              end
            end else begin
              r_estado <= BUSCANDO;
            end
          end
        end
        ALINEADO: begin
          if (w_frontera) begin
            o_salidas <= w_ventana_sig;
            o_valido  <= 1'b1;
            o_es_coma <= w_match;
            if (w_match) begin
              r_cuenta_errores <= '0;
            end
          end else if (w_match) begin
            // A comma off the boundary suggests the line has slipped
            r_cuenta_errores <= w_errores_inc;
            if (w_errores_inc == ERR_OBJ) begin
              r_estado   <= BUSCANDO;
              o_alineado <= 1'b0;
            end
          end
        end
        default: begin
          r_estado   <= BUSCANDO;
          o_alineado <= 1'b0;
        end
      endcase
    end
  end

endmodule
